led_run_ctrl: RTL and testbench

//   Sequencer for a bank of N_LED LEDs ("running light"). A free-running step

---
 rtl/led_run_ctrl_pkg.sv | 16 +
 rtl/led_step_timer.sv | 35 +++
 rtl/led_run_ctrl.sv | 126 ++++++++++++
 tb/tb_led_run_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_run_ctrl_pkg.sv
// Shared encodings for the running-light sequencer: mode codes, FSM states
// and bounce direction.
package led_run_ctrl_pkg;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_step_timer.sv
// Free-running step divider: counts while En, Tick while count==T_STEP,
// wraps to 0 after the terminal count; Clr forces the count to 0.
module led_step_timer #(
  parameter int             CW     = 23,
  parameter logic [CW-1:0]  T_STEP = 23'd20
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Clr,
  input  logic En,
  output logic Tick
);

  logic [CW-1:0] count_q, count_d;

  assign Tick = (count_q == T_STEP);

  always_comb begin
    count_d = count_q;
    if (Clr) begin
      count_d = '0;
    end else if (En) begin
      count_d = Tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_run_ctrl.sv
// Running-light sequencer: IDLE/RUN FSM, mode latched at Start, pattern
// advanced once per step tick from led_step_timer.
module led_run_ctrl
  import led_run_ctrl_pkg::*;
#(
  parameter int             N_LED  = 4,
  parameter int             CW     = 23,
  parameter logic [CW-1:0]  T_STEP = 23'd20
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start_Sig,
  input  logic             Stop_Sig,
  input  logic [1:0]       Mode,
  output logic [N_LED-1:0] LED_Out,
  output logic             Busy,
  output logic             Step_Done
);

  logic             state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             step_q, step_d;

  logic             tick;
  logic             step_now;
  logic [N_LED-1:0] led_init;
  logic [N_LED-1:0] led_adv;
  logic             dir_adv;

  led_step_timer #(
    .CW     (CW),
    .T_STEP (T_STEP)
  ) u_timer (
    .CLK  (CLK),
    .RSTn (RSTn),
    .Clr  (Start_Sig | Stop_Sig),
    .En   (state_q == ST_RUN),
    .Tick (tick)
  );

  // A Start or Stop on the terminal-count cycle suppresses that step.
  assign step_now = (state_q == ST_RUN) && tick && !Start_Sig && !Stop_Sig;

  always_comb begin
    led_init = '0;
    case (Mode)
      MODE_RIGHT: led_init[N_LED-1] = 1'b1;
      MODE_BLINK: led_init = '1;
      default:    led_init[0] = 1'b1;
    endcase
  end

  always_comb begin
    led_adv = led_q;
    dir_adv = dir_q;
    case (mode_q)
      MODE_LEFT:  led_adv = (led_q << 1) | (led_q >> (N_LED - 1));
      MODE_RIGHT: led_adv = (led_q >> 1) | (led_q << (N_LED - 1));
      MODE_BLINK: led_adv = ~led_q;
      default: begin
        // Bounce reflects off the end bits without wrapping; a single LED holds.
        if (N_LED > 1) begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[N_LED-1]) begin
              led_adv = led_q >> 1;
              dir_adv = DIR_RIGHT;
            end else begin
              led_adv = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_adv = led_q << 1;
              dir_adv = DIR_LEFT;
            end else begin
              led_adv = led_q >> 1;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    step_d  = 1'b0;
    if (Stop_Sig) begin
      state_d = ST_IDLE;
      led_d   = '0;
    end else if (Start_Sig) begin
      state_d = ST_RUN;
      mode_d  = Mode;
      dir_d   = DIR_LEFT;
      led_d   = led_init;
    end else if (step_now) begin
      led_d   = led_adv;
      dir_d   = dir_adv;
      step_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LEFT;
      dir_q   <= DIR_LEFT;
      led_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign LED_Out   = led_q;
  assign Busy      = (state_q == ST_RUN);
  assign Step_Done = step_q;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Bench for led_run_ctrl (N_LED=4, T_STEP=4): vector table, hand sequences
// for multi-cycle corners, and random pulses against a step-count model.
module tb_led_run_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Start_Sig = 1'b0;
  logic       Stop_Sig = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic [3:0] LED_Out;
  logic       Busy;
  logic       Step_Done;

  int n_cmp = 0;
  int n_fail = 0;

  led_run_ctrl #(
    .N_LED  (4),
    .CW     (23),
    .T_STEP (23'd4)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start_Sig (Start_Sig),
    .Stop_Sig  (Stop_Sig),
    .Mode      (Mode),
    .LED_Out   (LED_Out),
    .Busy      (Busy),
    .Step_Done (Step_Done)
  );

  always #5 CLK = ~CLK;

  // Reference: clocks elapsed since the start edge; step index = elapsed/5.
  bit m_run = 1'b0;
  int m_mode = 0;
  int m_el = 0;

  function automatic logic [3:0] pat(int m, int s);
    int p;
    case (m)
      0: return 4'(1 << (s % 4));
      1: return 4'(8 >> (s % 4));
      2: begin
        p = s % 6;
        if (p > 3) p = 6 - p;
        return 4'(1 << p);
      end
      default: return (s % 2 == 0) ? 4'hF : 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_led();
    return m_run ? pat(m_mode, m_el / 5) : 4'h0;
  endfunction

  function automatic logic exp_sd();
    return m_run && m_el != 0 && (m_el % 5 == 0);
  endfunction

  task automatic model_step();
    if (!RSTn) m_run = 1'b0;
    else if (Stop_Sig) m_run = 1'b0;
    else if (Start_Sig) begin
      m_run = 1'b1;
      m_mode = int'(Mode);
      m_el = 0;
    end else if (m_run) m_el++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic [1:0] mode;
    int         ncyc;
    logic [3:0] led;
    logic       busy;
    logic       sd;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic add(logic st, logic sp, logic [1:0] md, int n, logic [3:0] l,
                     logic b, logic s, string nm);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.ncyc = n;
    v.led = l; v.busy = b; v.sd = s; v.name = nm;
    vq.push_back(v);
  endtask

  logic [3:0] bexp [9];

  initial begin
    bexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
             4'b0010, 4'b0001, 4'b0010, 4'b0100};

    // Left rotation through a full wrap
    add(1, 0, 2'b00, 1, 4'b0001, 1, 0, "l_init");
    add(0, 0, 2'b00, 4, 4'b0001, 1, 0, "l_hold");
    add(0, 0, 2'b00, 1, 4'b0010, 1, 1, "l_s1");
    add(0, 0, 2'b00, 4, 4'b0010, 1, 0, "l_hold1");
    add(0, 0, 2'b00, 1, 4'b0100, 1, 1, "l_s2");
    add(0, 0, 2'b00, 5, 4'b1000, 1, 1, "l_s3");
    add(0, 0, 2'b00, 5, 4'b0001, 1, 1, "l_s4_wrap");
    // Restart on the terminal-count cycle
    add(0, 0, 2'b00, 4, 4'b0001, 1, 0, "rs_pre");
    add(1, 0, 2'b01, 1, 4'b1000, 1, 0, "rs_reload");
    add(0, 0, 2'b00, 4, 4'b1000, 1, 0, "rs_hold");
    add(0, 0, 2'b00, 1, 4'b0100, 1, 1, "rs_step");
    // Start and Stop together while running
    add(0, 0, 2'b00, 2, 4'b0100, 1, 0, "ss_pre");
    add(1, 1, 2'b11, 1, 4'b0000, 0, 0, "ss_stop");
    add(0, 0, 2'b00, 6, 4'b0000, 0, 0, "idle_hold");
    add(1, 0, 2'b10, 1, 4'b0001, 1, 0, "b_init");
    add(0, 1, 2'b00, 1, 4'b0000, 0, 0, "stop");

    #1;
    chk("rst_led", 32'(LED_Out), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_sd", 32'(Step_Done), 32'h0);
    #2 RSTn = 1'b1;

    foreach (vq[i]) begin
      Start_Sig = vq[i].start;
      Stop_Sig  = vq[i].stop;
      Mode      = vq[i].mode;
      tick();
      Start_Sig = 1'b0;
      Stop_Sig  = 1'b0;
      for (int k = 1; k < vq[i].ncyc; k++) tick();
      chk({vq[i].name, "_led"}, 32'(LED_Out), 32'(vq[i].led));
      chk({vq[i].name, "_busy"}, 32'(Busy), 32'(vq[i].busy));
      chk({vq[i].name, "_sd"}, 32'(Step_Done), 32'(vq[i].sd));
    end

    // Bounce for eight steps
    Mode = 2'b10; Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
    chk("bnc_0", 32'(LED_Out), 32'(bexp[0]));
    for (int s = 1; s <= 8; s++) begin
      repeat (5) tick();
      chk($sformatf("bnc_%0d", s), 32'(LED_Out), 32'(bexp[s]));
      chk($sformatf("bnc_sd_%0d", s), 32'(Step_Done), 32'h1);
    end

    // Mode changes mid-run are ignored
    Mode = 2'b01; Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
    Mode = 2'b11;
    chk("r_init", 32'(LED_Out), 32'h8);
    for (int s = 1; s <= 3; s++) begin
      repeat (5) tick();
      chk($sformatf("r_step_%0d", s), 32'(LED_Out), 32'(4'(8 >> s)));
    end

    // Asynchronous reset mid-run in blink mode
    Mode = 2'b11; Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
    chk("bl_init", 32'(LED_Out), 32'hF);
    repeat (5) tick();
    chk("bl_s1", 32'(LED_Out), 32'h0);
    repeat (5) tick();
    chk("bl_s2", 32'(LED_Out), 32'hF);
    repeat (2) tick();
    #3 RSTn = 1'b0;
    #1;
    chk("arst_led", 32'(LED_Out), 32'h0);
    chk("arst_busy", 32'(Busy), 32'h0);
    chk("arst_sd", 32'(Step_Done), 32'h0);
    tick();
    RSTn = 1'b1;
    repeat (8) tick();
    chk("post_rst_led", 32'(LED_Out), 32'h0);
    chk("post_rst_busy", 32'(Busy), 32'h0);

    // Random pulses against the model
    for (int c = 0; c < 800; c++) begin
      Start_Sig = ($urandom_range(0, 11) == 0);
      Stop_Sig  = ($urandom_range(0, 39) == 0);
      Mode      = 2'($urandom_range(0, 3));
      tick();
      chk("rnd_led", 32'(LED_Out), 32'(exp_led()));
      chk("rnd_busy", 32'(Busy), 32'(m_run));
      chk("rnd_sd", 32'(Step_Done), 32'(exp_sd()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
